// File: rtl/reg_bus_arbiter.sv
// ============================================================================
//  Module      : reg_bus_arbiter
//  Description : Two-port req/ack arbiter (SPI = port 0, I2C = port 1) in
//                front of the single reg_bank bus; one access at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bus_arbiter #(
    parameter int REG_W  = 8,
    parameter int ADDR_W = 8,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,

    input  logic              p0_req,
    input  logic              p0_wr_rdn,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [REG_W-1:0]  p0_wdata,
    output logic              p0_ack,
    output logic [REG_W-1:0]  p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_wr_rdn,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [REG_W-1:0]  p1_wdata,
    output logic              p1_ack,
    output logic [REG_W-1:0]  p1_rdata,
    output logic              p1_err,

    output logic              bus_wr_rdn,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [REG_W-1:0]  bus_wdata,
    output logic              bus_we,
    input  logic [REG_W-1:0]  bus_rdata,
    input  logic              bus_err,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic              w_grant_en;
    logic              w_capture;
    logic              w_resp;
    logic              w_pick1;

    logic              r_grant;
    logic              r_last_grant;
    logic              r_bus_wr_rdn;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [REG_W-1:0]  r_bus_wdata;
    logic              r_bus_we;
    logic              r_p0_ack;
    logic [REG_W-1:0]  r_p0_rdata;
    logic              r_p0_err;
    logic              r_p1_ack;
    logic [REG_W-1:0]  r_p1_rdata;
    logic              r_p1_err;

    // Port 1 wins when alone, or in round-robin mode when port 0 had the last turn.
    assign w_pick1 = p1_req && (!p0_req || ((RR != 0) && !r_last_grant));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_capture    = 1'b0;
        w_resp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ena && (p0_req || p1_req)) begin
                    w_grant_en   = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_capture    = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_resp       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_bus_wr_rdn <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_we     <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p0_err     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p1_rdata   <= '0;
            r_p1_err     <= 1'b0;
        end else begin
            // Strobes last exactly one cycle.
            r_bus_we <= 1'b0;
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;

            if (w_grant_en) begin
                r_grant      <= w_pick1;
                r_bus_wr_rdn <= w_pick1 ? p1_wr_rdn : p0_wr_rdn;
                r_bus_addr   <= w_pick1 ? p1_addr   : p0_addr;
                r_bus_wdata  <= w_pick1 ? p1_wdata  : p0_wdata;
                r_bus_we     <= w_pick1 ? p1_wr_rdn : p0_wr_rdn;
            end

            // Reads refresh rdata; writes leave the previous read value intact.
            if (w_capture) begin
                if (r_grant) begin
                    if (!r_bus_wr_rdn) begin
                        r_p1_rdata <= bus_rdata;
                    end
                    r_p1_err <= bus_err;
                    r_p1_ack <= 1'b1;
                end else begin
                    if (!r_bus_wr_rdn) begin
                        r_p0_rdata <= bus_rdata;
                    end
                    r_p0_err <= bus_err;
                    r_p0_ack <= 1'b1;
                end
            end

            if (w_resp) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign p0_ack     = r_p0_ack;
    assign p0_rdata   = r_p0_rdata;
    assign p0_err     = r_p0_err;
    assign p1_ack     = r_p1_ack;
    assign p1_rdata   = r_p1_rdata;
    assign p1_err     = r_p1_err;
    assign bus_wr_rdn = r_bus_wr_rdn;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_we     = r_bus_we;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
